// File: rtl/rle_if.sv
// rle_if: character stream in, (symbol, count, last) pair stream out.
// slave is the encoder's view, master is the producer/consumer's view.
interface rle_if #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 4
);
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [DATA_W-1:0]  out_sym;
    logic [COUNT_W-1:0] out_count;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_sym, out_count, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_sym, out_count, out_last, out_valid
    );
endinterface

// File: rtl/rle_compressor.sv
// rle_compressor: streaming run-length encoder emitting (symbol, count, last) pairs.
// Latency 1 cycle from the closing beat; in_ready drops on an output stall or while a second pair waits.
module rle_compressor #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    rle_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [COUNT_W-1:0] MAX_RUN = '1;
    localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

    state_t             state;
    logic [DATA_W-1:0]  cur_sym;
    logic [COUNT_W-1:0] cur_cnt;
    logic [DATA_W-1:0]  stash;

    logic [DATA_W-1:0]  out_sym;
    logic [COUNT_W-1:0] out_count;
    logic               out_last;
    logic               out_valid;

    logic in_ready;
    logic accept;
    logic emit_done;
    logic extend;

    // Ready depends only on registered state and out_ready, never on in_valid.
    assign in_ready  = rst_n && (state != FLUSH) && (!out_valid || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign emit_done = out_valid && bus.out_ready;
    assign extend    = (bus.in_data == cur_sym) && (cur_cnt != MAX_RUN);

    assign bus.in_ready  = in_ready;
    assign bus.out_sym   = out_sym;
    assign bus.out_count = out_count;
    assign bus.out_last  = out_last;
    assign bus.out_valid = out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_sym   <= '0;
            cur_cnt   <= '0;
            stash     <= '0;
            out_sym   <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // Any pair loaded below overrides this drop in the same cycle.
            if (emit_done) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.in_last) begin
                            out_sym   <= bus.in_data;
                            out_count <= ONE;
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            cur_sym <= bus.in_data;
                            cur_cnt <= ONE;
                            state   <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (accept) begin
                        if (extend) begin
                            if (bus.in_last) begin
                                out_sym   <= cur_sym;
                                out_count <= cur_cnt + ONE;
                                out_last  <= 1'b1;
                                out_valid <= 1'b1;
                                cur_cnt   <= '0;
                                state     <= IDLE;
                            end else begin
                                cur_cnt <= cur_cnt + ONE;
                            end
                        end else begin
                            // Symbol change or saturated count closes the current run.
                            out_sym   <= cur_sym;
                            out_count <= cur_cnt;
                            out_last  <= 1'b0;
                            out_valid <= 1'b1;
                            if (bus.in_last) begin
                                stash   <= bus.in_data;
                                cur_cnt <= '0;
                                state   <= FLUSH;
                            end else begin
                                cur_sym <= bus.in_data;
                                cur_cnt <= ONE;
                            end
                        end
                    end
                end

                FLUSH: begin
                    if (emit_done) begin
                        out_sym   <= stash;
                        out_count <= ONE;
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rle_compressor.sv
// Bench for rle_compressor: directed scenarios plus a randomized handshake run,
// with output pairs compared against a run-splitting reference model.
module tb_rle_compressor;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int MAXRUN = 15;

    typedef struct packed {
        logic [7:0] sym;
        logic [3:0] cnt;
        logic       last;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rle_if #(.DATA_W(DW), .COUNT_W(CW)) bus ();

    rle_compressor #(.DATA_W(DW), .COUNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] beat_d[$];
    bit         beat_l[$];
    pair_t      got[$];
    pair_t      exp_q[$];
    bit         rand_ready = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance to 1 time unit after the edge.
    task automatic step(output bit acc);
        if (rand_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
        #2;
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            beat_d.push_back(bus.in_data);
            beat_l.push_back(bus.in_last);
        end
        if (bus.out_valid && bus.out_ready)
            got.push_back('{sym: bus.out_sym, cnt: bus.out_count, last: bus.out_last});
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit l);
        bit acc;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int i = 0; i < 100 && !acc; i++) step(acc);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic drain();
        bit a;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (!bus.out_valid) break;
            step(a);
        end
        check("drain_idle", {31'd0, bus.out_valid}, 32'd0);
    endtask

    // Reference: find each maximal run inside a packet, cut it into MAXRUN chunks;
    // the run's last chunk carries LAST if the run ends the packet.
    task automatic build_expected();
        int i, len, rem;
        logic [7:0] s;
        bit endp;
        exp_q.delete();
        i = 0;
        while (i < beat_d.size()) begin
            s = beat_d[i];
            len = 1;
            while (!beat_l[i + len - 1] && (i + len < beat_d.size()) && beat_d[i + len] == s) len++;
            endp = beat_l[i + len - 1];
            rem = len;
            while (rem > MAXRUN) begin
                exp_q.push_back('{sym: s, cnt: 4'(MAXRUN), last: 1'b0});
                rem -= MAXRUN;
            end
            exp_q.push_back('{sym: s, cnt: 4'(rem), last: endp});
            i += len;
        end
    endtask

    task automatic clear_stream();
        got.delete();
        beat_d.delete();
        beat_l.delete();
    endtask

    task automatic compare_stream(input string tag);
        int n;
        build_expected();
        check({tag, "_npairs"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check({tag, "_sym"},  {24'd0, got[k].sym},  {24'd0, exp_q[k].sym});
            check({tag, "_cnt"},  {28'd0, got[k].cnt},  {28'd0, exp_q[k].cnt});
            check({tag, "_last"}, {31'd0, got[k].last}, {31'd0, exp_q[k].last});
        end
        clear_stream();
    endtask

    task automatic check_out(input string tag, input logic [7:0] s, input logic [3:0] c, input bit l);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_sym"},   {24'd0, bus.out_sym},   {24'd0, s});
        check({tag, "_cnt"},   {28'd0, bus.out_count}, {28'd0, c});
        check({tag, "_last"},  {31'd0, bus.out_last},  {31'd0, l});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        logic [7:0] prev;
        logic [7:0] d;
        bit l;
        int exp_bytes, zero_cnt, diffs, n_in_last, n_out_last;
        logic [7:0] expand[$];

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_sym",   {24'd0, bus.out_sym},   32'd0);
        check("rst_out_count", {28'd0, bus.out_count}, 32'd0);
        check("rst_out_last",  {31'd0, bus.out_last},  32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // "AAAB" with LAST on B: FLUSH holds off input for exactly one cycle
        send(8'h41, 0);
        send(8'h41, 0);
        send(8'h41, 0);
        send(8'h42, 1);
        check_out("t1_p0", 8'h41, 4'd3, 1'b0);
        check("t1_flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step(a);
        check_out("t1_p1", 8'h42, 4'd1, 1'b1);
        check("t1_after_in_ready", {31'd0, bus.in_ready}, 32'd1);
        drain();
        compare_stream("t1");

        // 20 identical beats: saturate at 15, remainder 5
        for (int i = 0; i < 20; i++) send(8'h35, i == 19);
        drain();
        check("t2_npairs", got.size(), 32'd2);
        check("t2_cnt0", {28'd0, got[0].cnt}, 32'd15);
        check("t2_cnt1", {28'd0, got[1].cnt}, 32'd5);
        compare_stream("t2");

        // Single LAST beat from IDLE
        send(8'h40, 1);
        check_out("t3", 8'h40, 4'd1, 1'b1);
        check("t3_in_ready", {31'd0, bus.in_ready}, 32'd1);
        drain();
        compare_stream("t3");

        // Output stall while a second pair is pending
        bus.out_ready = 1'b0;
        send(8'h69, 0);
        send(8'h69, 0);
        send(8'hA5, 1);
        for (int k = 0; k < 5; k++) begin
            check_out("t4_hold", 8'h69, 4'd2, 1'b0);
            check("t4_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            step(a);
        end
        bus.out_ready = 1'b1;
        step(a);
        check_out("t4_p1", 8'hA5, 4'd1, 1'b1);
        drain();
        compare_stream("t4");

        // Reset mid-run discards the open run
        send(8'h74, 0);
        send(8'h74, 0);
        check("t5_no_emit", got.size(), 32'd0);
        rst_n = 1'b0;
        #2;
        check("t5_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t5_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_stream();
        send(8'h63, 1);
        drain();
        check("t5_npairs", got.size(), 32'd1);
        compare_stream("t5");

        // Randomized handshakes over 1000 bytes from {0x41,0x42}
        rand_ready = 1;
        prev = 8'h41;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) != 0) d = prev;
            else d = (prev == 8'h41) ? 8'h42 : 8'h41;
            prev = d;
            l = (i == 999) || ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(d, l);
        end
        rand_ready = 0;
        drain();

        expand.delete();
        zero_cnt = 0;
        n_out_last = 0;
        foreach (got[k]) begin
            if (got[k].cnt == 4'd0) zero_cnt++;
            if (got[k].last) n_out_last++;
            for (int r = 0; r < got[k].cnt; r++) expand.push_back(got[k].sym);
        end
        n_in_last = 0;
        foreach (beat_l[k]) if (beat_l[k]) n_in_last++;
        exp_bytes = beat_d.size();
        diffs = 0;
        for (int k = 0; k < exp_bytes; k++)
            if (k >= expand.size() || expand[k] !== beat_d[k]) diffs++;
        check("rand_beats_sent", exp_bytes, 32'd1000);
        check("rand_expand_len", expand.size(), exp_bytes);
        check("rand_expand_diff", diffs, 32'd0);
        check("rand_zero_count", zero_cnt, 32'd0);
        check("rand_last_count", n_out_last, n_in_last);
        compare_stream("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
